// File: rtl/spiflash_pkg.sv
// Shared types and constants for the SPI NOR flash read arbiter.
package spiflash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StCmd,
    StData,
    StDone
  } state_e;

  typedef enum logic {
    PortF = 1'b0,
    PortD = 1'b1
  } port_e;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_FASTREAD = 8'h0B;

  // Width of the serialised command word: opcode, 24-bit address, one spare byte.
  localparam int unsigned TxW = 40;

  // SCLK half-period in clk cycles.
  function automatic logic [1:0] half_period(input logic fast);
    return fast ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: shifts a left-aligned word out on MOSI and collects MISO,
// holding SCLK low for H clk then high for H clk per bit.
module spi_shift_engine
  import spiflash_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [5:0]     nbits_i,
  input  logic [TxW-1:0] tx_i,
  input  logic [1:0]     half_i,
  input  logic           miso_i,
  output logic           sclk_o,
  output logic           mosi_o,
  output logic           bit_end_o,
  output logic [5:0]     bits_left_o,
  output logic [7:0]     rx_o,
  output logic           done_o
);

  logic           busy_q, busy_d;
  logic           sclk_q, sclk_d;
  logic [TxW-1:0] tx_q, tx_d;
  logic [5:0]     left_q, left_d;
  logic [1:0]     half_q, half_d;
  logic [1:0]     hcnt_q, hcnt_d;
  logic [7:0]     rx_q, rx_d;
  logic           phase_end;

  assign phase_end   = busy_q && (hcnt_q == half_q - 2'd1);
  assign bit_end_o   = phase_end && sclk_q;
  assign done_o      = bit_end_o && (left_q == 6'd1);
  assign sclk_o      = sclk_q;
  // Current bit always sits in the MSB; zeros shift in, so MOSI rests low when idle.
  assign mosi_o      = tx_q[TxW-1];
  assign bits_left_o = left_q;
  assign rx_o        = rx_q;

  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    tx_d   = tx_q;
    left_d = left_q;
    half_d = half_q;
    hcnt_d = hcnt_q;
    rx_d   = rx_q;
    if (load_i) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      tx_d   = tx_i;
      left_d = nbits_i;
      half_d = half_i;
      hcnt_d = 2'd0;
    end else if (busy_q) begin
      hcnt_d = phase_end ? 2'd0 : hcnt_q + 2'd1;
      if (phase_end && !sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
      end
      if (bit_end_o) begin
        sclk_d = 1'b0;
        tx_d   = {tx_q[TxW-2:0], 1'b0};
        left_d = left_q - 6'd1;
        if (left_q == 6'd1) begin
          busy_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      tx_q   <= '0;
      left_q <= '0;
      half_q <= 2'd1;
      hcnt_q <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      tx_q   <= tx_d;
      left_q <= left_d;
      half_q <= half_d;
      hcnt_q <= hcnt_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/spiflash_read_arbiter.sv
// Round-robin arbiter sharing one SPI NOR flash between fetch (F) and data (D) byte reads,
// keeping CS low so a read at last address + 1 needs only 8 SCLKs.
// Define SPIFLASH_FASTREAD_EN to use FAST READ (0x0B + 8 dummy clocks) on restarts.
module spiflash_read_arbiter
  import spiflash_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CS_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fast,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_valid,
  output logic [7:0]        f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_valid,
  output logic [7:0]        d_data,
  input  logic              flush,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

`ifdef SPIFLASH_FASTREAD_EN
  localparam logic [7:0] CmdByte = CMD_FASTREAD;
  localparam logic [5:0] NsBits  = 6'd48;
`else
  localparam logic [7:0] CmdByte = CMD_READ;
  localparam logic [5:0] NsBits  = 6'd40;
`endif
  localparam logic [5:0] SeqBits = 6'd8;
  localparam logic [7:0] GapLast = (CS_GAP > 0) ? 8'(CS_GAP - 1) : 8'd0;
  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  port_e             rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [1:0]        half_q, half_d;
  logic              stream_open_q, stream_open_d;
  logic              cs_n_q, cs_n_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic              f_valid_q, f_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [7:0]        f_data_q, f_data_d;
  logic [7:0]        d_data_q, d_data_d;

  logic              grant_any;
  port_e             grant_port;
  logic [ADDR_W-1:0] grant_addr;
  logic              seq_hit;

  logic              eng_load;
  logic [5:0]        eng_nbits;
  logic [TxW-1:0]    eng_tx;
  logic [1:0]        eng_half;
  logic              eng_bit_end;
  logic [5:0]        eng_left;
  logic [7:0]        eng_rx;
  logic              eng_done;

  always_comb begin
    grant_any = f_req | d_req;
    if (f_req && d_req) begin
      grant_port = (rr_last_q == PortD) ? PortF : PortD;
    end else if (d_req) begin
      grant_port = PortD;
    end else begin
      grant_port = PortF;
    end
    grant_addr = (grant_port == PortD) ? d_addr : f_addr;
    // All-ones never counts as sequential: the flash would continue past it, not wrap.
    seq_hit = stream_open_q && (last_addr_q != '1) && (grant_addr == last_addr_q + AddrOne);
  end

  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    rr_last_d     = rr_last_q;
    addr_d        = addr_q;
    last_addr_d   = last_addr_q;
    half_d        = half_q;
    stream_open_d = stream_open_q;
    cs_n_d        = cs_n_q;
    gap_cnt_d     = gap_cnt_q;
    f_valid_d     = 1'b0;
    d_valid_d     = 1'b0;
    f_data_d      = f_data_q;
    d_data_d      = d_data_q;
    eng_load      = 1'b0;
    eng_nbits     = SeqBits;
    eng_tx        = '0;
    eng_half      = half_q;

    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          port_d = grant_port;
          addr_d = grant_addr;
          half_d = half_period(fast);
          if (seq_hit) begin
            state_d  = StData;
            eng_load = 1'b1;
            eng_half = half_period(fast);
          end else begin
            state_d   = StGap;
            cs_n_d    = 1'b1;
            gap_cnt_d = 8'd0;
          end
        end else if (flush) begin
          cs_n_d        = 1'b1;
          stream_open_d = 1'b0;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d   = StCmd;
          cs_n_d    = 1'b0;
          eng_load  = 1'b1;
          eng_nbits = NsBits;
          eng_tx    = {CmdByte, 24'(addr_q), 8'h00};
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StCmd: begin
        // The engine runs straight through; only the final 8 bits are the data byte.
        if (eng_bit_end && (eng_left == SeqBits + 6'd1)) begin
          state_d = StData;
        end
      end
      StData: begin
        if (eng_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (port_q == PortD) begin
          d_valid_d = 1'b1;
          d_data_d  = eng_rx;
        end else begin
          f_valid_d = 1'b1;
          f_data_d  = eng_rx;
        end
        last_addr_d   = addr_q;
        stream_open_d = 1'b1;
        rr_last_d     = port_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      port_q        <= PortF;
      rr_last_q     <= PortD;
      addr_q        <= '0;
      last_addr_q   <= '0;
      half_q        <= 2'd1;
      stream_open_q <= 1'b0;
      cs_n_q        <= 1'b1;
      gap_cnt_q     <= '0;
      f_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      f_data_q      <= '0;
      d_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      rr_last_q     <= rr_last_d;
      addr_q        <= addr_d;
      last_addr_q   <= last_addr_d;
      half_q        <= half_d;
      stream_open_q <= stream_open_d;
      cs_n_q        <= cs_n_d;
      gap_cnt_q     <= gap_cnt_d;
      f_valid_q     <= f_valid_d;
      d_valid_q     <= d_valid_d;
      f_data_q      <= f_data_d;
      d_data_q      <= d_data_d;
    end
  end

  spi_shift_engine u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (eng_load),
    .nbits_i     (eng_nbits),
    .tx_i        (eng_tx),
    .half_i      (eng_half),
    .miso_i      (spi_miso),
    .sclk_o      (spi_sclk),
    .mosi_o      (spi_mosi),
    .bit_end_o   (eng_bit_end),
    .bits_left_o (eng_left),
    .rx_o        (eng_rx),
    .done_o      (eng_done)
  );

  assign spi_cs_n = cs_n_q;
  assign f_valid  = f_valid_q;
  assign d_valid  = d_valid_q;
  assign f_data   = f_data_q;
  assign d_data   = d_data_q;

endmodule

// File: doc/spiflash_read_arbiter.md
Name: spiflash_read_arbiter

Overview:
Shares one SPI NOR flash (mode 0, READ 0x03) between two read requesters: instruction fetch (port F) and data/table reads (port D).
- Serves one byte per transaction.
- Keeps CS asserted between transactions, so a read at last address + 1 costs only 8 SCLK periods.
- Sits between the CPU core's fetch/operand logic and the flash pins.

Parameters:
ADDR_W, 12, byte address width; the flash address sent is {zero-pad to 24 bits, addr}.
CS_GAP, 2, minimum clk cycles cs_n is held high before a new command.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
fast  in  1  1: SCLK half-period = 1 clk; 0: 2 clk; sampled only at grant
f_req  in  1  fetch request, level; held until f_valid
f_addr  in  ADDR_W  fetch byte address, stable while f_req
f_valid  out  1  one-cycle pulse, f_data valid
f_data  out  8  read byte, held until next f_valid
d_req  in  1  data request, level
d_addr  in  ADDR_W  data byte address
d_valid  out  1  one-cycle pulse
d_data  out  8  read byte, held until next d_valid
flush  in  1  close open stream (cs_n high) at next idle
spi_sclk  out  1  SPI clock, idle low
spi_cs_n  out  1  chip select, active-low
spi_mosi  out  1  serial out, changes on SCLK falling edge
spi_miso  in  1  serial in, sampled with rising SCLK

Behaviour:
Reset:
- spi_cs_n=1, spi_sclk=0, spi_mosi=0.
- f_valid=d_valid=0, f_data=d_data=0.
- stream_open=0, last_addr=0, rr_last=D (so F wins the first tie).
- Reset mid-transfer aborts it immediately; no valid pulse is produced.

States: IDLE, GAP, CMD, DATA, DONE.

IDLE:
- Grant selection:
  - Only one of f_req / d_req high: grant that one.
  - Both high: grant the port not in rr_last (round-robin).
- Latch addr, port and H (=fast?1:2).
- seq = stream_open && addr == last_addr+1, computed in ADDR_W bits with no wrap credit. last_addr = all-ones is never sequential.
- seq=1: go to DATA.
- Else: go to GAP.
- flush=1 with no request: cs_n<=1, stream_open<=0.

GAP:
- cs_n=1 for CS_GAP cycles, then cs_n=0, go to CMD.

CMD:
- Shift 32 bits MSB-first: 0x03, then 24-bit address.
- Each bit: SCLK low for H clk (mosi updated at its start), high for H clk.

DATA:
- 8 SCLK periods; shift spi_miso in on each rising edge, MSB first.

DONE (1 cycle):
- Write the byte to the granted port's data register and pulse its valid.
- last_addr<=addr, stream_open<=1, rr_last<=port.
- Return to IDLE.
- The requester may drop req in the cycle after valid. A req still high in IDLE is a new request.

Latency (cycle 0 = IDLE grant cycle):
- Non-sequential: valid at cycle 1+CS_GAP+80H+1 (fast=1, CS_GAP=2: cycle 84).
- Sequential: valid at cycle 1+16H+1 (fast=1: cycle 18; fast=0: cycle 34).

Stream rules:
- The stream is shared: sequential detection compares against the last address served, regardless of port.
- An address change by the other port forces a restart.
- Changes to f_req/d_req/addr during a transfer are ignored.
- A request that drops before grant is never served.

Optional Feature:
SPIFLASH_FASTREAD_EN
- Defined: non-sequential transactions use 0x0B (FAST READ) with 8 dummy SCLK periods after the address. CMD shifts 40 bits; non-sequential latency becomes 1+CS_GAP+96H+1. Sequential timing is unchanged.
- Undefined: 0x03 only, as above.

Decomposition:
Package spiflash_pkg:
- state enum.
- CMD_READ=8'h03, CMD_FASTREAD=8'h0B.
- port id encoding F=0, D=1.

Sub-module spi_shift_engine:
- Takes load, bit count, 40-bit tx word and H.
- Drives sclk/mosi, samples miso, and signals done.
- The arbiter FSM owns grant, cs_n and the stream tracking.

Test Plan:
1. Reset, then f_req addr 0x123, fast=1, flash model byte 0xA5 → mosi bits 03 00 01 23; cs_n high for cycles 1–2; f_valid at cycle 84 with f_data=0xA5.
2. Follow-up f_req 0x124 → cs_n stays low, no command bits, exactly 8 SCLKs; f_valid 18 cycles after grant.
3. f_req and d_req high together, f at 0x010, d at 0x200 → F served first, then D with a full restart (cs_n gap observed); then both high again → D... wait, rr_last=D so F is served next.
4. Stream at 0xFFF, then request 0x000 → full restart with address 0x000000, not a sequential read.
5. rst_n low for 1 cycle at cycle 40 of a CMD shift → cs_n=1 and sclk=0 next cycle, no valid pulse; the next request at last_addr+1 still does a full restart.
6. fast=0, non-sequential read → SCLK period 4 clk; valid at cycle 164; toggling fast mid-transfer does not change timing.
